// File: rtl/prng_arbiter.sv
// prng_arbiter: round-robin sharing of one xor_prng among NUM_REQ requesters.
// The granted requester receives BURST_LEN random words over valid/ready.
// The PRNG is enabled only on accepted beats, so each word is delivered once.
// Optional macro PRNG_ARB_STATS_EN adds a saturating accepted-beat counter.
module prng_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int RAND_W    = 12,
  parameter int BURST_LEN = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] rand_ready,
  output logic [NUM_REQ-1:0] grant,
  output logic [NUM_REQ-1:0] rand_valid,
  output logic [RAND_W-1:0]  rand_data,
  output logic [NUM_REQ-1:0] done,
  output logic               prng_enable,
  input  logic [RAND_W-1:0]  prng_rand,
  output logic [31:0]        stat_beats
);

  localparam int               PTR_W     = $clog2(NUM_REQ);
  localparam logic [7:0]       LAST_BEAT = 8'(BURST_LEN - 1);
  localparam logic [PTR_W-1:0] PTR_RST   = PTR_W'(NUM_REQ - 1);
  localparam logic [PTR_W:0]   NREQ_EXT  = (PTR_W+1)'(NUM_REQ);

  typedef enum logic {S_IDLE, S_BURST} state_t;

  state_t             r_state, w_state_nxt;
  logic [NUM_REQ-1:0] r_grant, w_grant_nxt;
  logic [NUM_REQ-1:0] r_done, w_done_nxt;
  logic [PTR_W-1:0]   r_ptr, w_ptr_nxt;
  logic [7:0]         r_cnt, w_cnt_nxt;

  logic [NUM_REQ-1:0] w_elig;
  logic [NUM_REQ-1:0] w_hold;
  logic               w_active;
  logic               w_beat;
  logic               w_found;
  logic [PTR_W-1:0]   w_winner;
  logic [PTR_W:0]     w_idx;

  // A requester being told it is done this cycle must not be re-granted at once.
  assign w_elig   = req & ~r_done;
  // Winner still requesting; a withdrawn request blocks the beat and the PRNG.
  assign w_hold   = r_grant & req;
  assign w_active = |w_hold;
  assign w_beat   = (r_state == S_BURST) && (|(w_hold & rand_ready));

  assign grant       = r_grant;
  assign rand_valid  = r_grant;
  assign done        = r_done;
  assign rand_data   = prng_rand;
  assign prng_enable = w_beat;

  // Round-robin search: first eligible requester after the last winner, with wrap.
  always_comb begin
    w_found  = 1'b0;
    w_winner = r_ptr;
    w_idx    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = {1'b0, r_ptr} + (PTR_W+1)'(k);
      if (w_idx >= NREQ_EXT) w_idx = w_idx - NREQ_EXT;
      if (!w_found && w_elig[w_idx[PTR_W-1:0]]) begin
        w_found  = 1'b1;
        w_winner = w_idx[PTR_W-1:0];
      end
    end
  end

  // Next-state logic: grant in IDLE, count beats / handle withdrawal in BURST.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = '0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nxt           = S_BURST;
          w_grant_nxt           = '0;
          w_grant_nxt[w_winner] = 1'b1;
          w_ptr_nxt             = w_winner;
          w_cnt_nxt             = '0;
        end
      end
      S_BURST: begin
        if (!w_active) begin
          w_state_nxt = S_IDLE;
          w_grant_nxt = '0;
        end else if (w_beat) begin
          if (r_cnt == LAST_BEAT) begin
            w_state_nxt = S_IDLE;
            w_grant_nxt = '0;
            w_done_nxt  = r_grant;
          end else begin
            w_cnt_nxt = r_cnt + 8'd1;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  // State register; reset discards any burst in flight without a done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_done  <= '0;
      r_ptr   <= PTR_RST;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_done  <= w_done_nxt;
      r_ptr   <= w_ptr_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

`ifdef PRNG_ARB_STATS_EN
  logic [31:0] r_stat;

  // Saturating count of accepted beats, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat <= '0;
    end else if (w_beat && (r_stat != 32'hFFFF_FFFF)) begin
      r_stat <= r_stat + 32'd1;
    end
  end

  assign stat_beats = r_stat;
`else
  assign stat_beats = 32'd0;
`endif

endmodule

// File: tb/tb_prng_arbiter.sv
// Testbench for prng_arbiter: directed scenarios plus a randomized phase,
// all checked against a behavioural model of the arbitration rules.
module tb_prng_arbiter;

  localparam int NR = 4;
  localparam int RW = 12;
  localparam int BL = 2;
  localparam logic [RW-1:0] SEED = 12'h5A5;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic [NR-1:0] req   = '0;
  logic [NR-1:0] rdy   = '0;
  logic [NR-1:0] grant, rand_valid, done;
  logic          prng_enable;
  logic [RW-1:0] rand_data;
  logic [RW-1:0] prng_q = SEED;
  logic [31:0]   stat_beats;

  int checks   = 0;
  int failures = 0;

  // Behavioural model: owner (-1 when idle), last winner, beats delivered
  int            m_owner;
  int            m_last;
  int            m_cnt;
  logic [NR-1:0] m_done;
  logic [RW-1:0] m_word = SEED;
  logic [31:0]   m_stat;

  always #5 clk = ~clk;

  function automatic logic [RW-1:0] xs(input logic [RW-1:0] x);
    logic [RW-1:0] y;
    y = x ^ (x << 3);
    y = y ^ (y >> 5);
    y = y ^ (y << 7);
    return y;
  endfunction

  // Stand-in for xor_prng: registered output, advances when enabled
  always @(posedge clk) if (prng_enable) prng_q <= xs(prng_q);

  prng_arbiter #(.NUM_REQ(NR), .RAND_W(RW), .BURST_LEN(BL)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .rand_ready(rdy),
    .grant(grant), .rand_valid(rand_valid), .rand_data(rand_data),
    .done(done), .prng_enable(prng_enable), .prng_rand(prng_q),
    .stat_beats(stat_beats)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_last  = NR - 1;
    m_cnt   = 0;
    m_done  = '0;
    m_stat  = 0;
  endtask

  // Apply one clock edge to the model using the inputs that were present
  task automatic model_step();
    logic [NR-1:0] nd;
    logic [NR-1:0] el;
    bit            hit;
    nd  = '0;
    hit = 0;
    if (m_owner < 0) begin
      el = req & ~m_done;
      for (int k = 1; k <= NR; k++) begin
        int c;
        c = (m_last + k) % NR;
        if (!hit && el[c]) begin
          hit = 1; m_owner = c; m_last = c; m_cnt = 0;
        end
      end
    end else if (!req[m_owner]) begin
      m_owner = -1;
    end else if (rdy[m_owner]) begin
      m_cnt++;
      m_word = xs(m_word);
      if (m_stat != 32'hFFFF_FFFF) m_stat++;
      if (m_cnt == BL) begin
        nd[m_owner] = 1'b1;
        m_owner = -1;
      end
    end
    m_done = nd;
  endtask

  function automatic logic [31:0] exp_stat();
`ifdef PRNG_ARB_STATS_EN
    return m_stat;
`else
    return 32'd0;
`endif
  endfunction

  task automatic check_all(input string tag);
    logic [NR-1:0] eg;
    logic          een;
    eg  = '0;
    een = 1'b0;
    if (m_owner >= 0) begin
      eg[m_owner] = 1'b1;
      een = req[m_owner] & rdy[m_owner];
    end
    chk({tag, ".grant"}, 32'(grant), 32'(eg));
    chk({tag, ".valid"}, 32'(rand_valid), 32'(eg));
    chk({tag, ".done"},  32'(done), 32'(m_done));
    chk({tag, ".en"},    32'(prng_enable), 32'(een));
    chk({tag, ".data"},  32'(rand_data), 32'(m_word));
    chk({tag, ".stat"},  stat_beats, exp_stat());
  endtask

  task automatic step_edge();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic settle(input string tag);
    #1;
    check_all(tag);
  endtask

  task automatic rr_round(input string tag);
    int            order[$];
    logic [NR-1:0] prev;
    prev = '0;
    step_edge(); req = '1; rdy = '1; settle(tag);
    for (int c = 0; c < 60; c++) begin
      step_edge();
      req = req & ~m_done;
      settle(tag);
      if (grant != '0 && prev == '0)
        for (int i = 0; i < NR; i++) if (grant[i]) order.push_back(i);
      prev = grant;
      if (req == '0 && grant == '0 && done == '0) break;
    end
    chk({tag, ".count"}, 32'(order.size()), 32'(NR));
    for (int i = 0; i < NR; i++)
      chk({tag, ".order"}, (i < order.size()) ? 32'(order[i]) : 32'hFFFF_FFFF, 32'(i));
  endtask

  task automatic run_burst(input int idx, input int stall);
    logic [NR-1:0] one;
    one = '0;
    one[idx] = 1'b1;
    step_edge(); req = one; rdy = '1; settle("burst");
    step_edge(); settle("burst");
    chk("burst.grant", 32'(grant), 32'(one));
    if (stall > 0) begin
      rdy = '0; settle("burst");
      for (int s = 1; s < stall; s++) begin step_edge(); settle("burst"); end
      step_edge(); rdy = '1; settle("burst");
    end
    for (int b = 0; b < BL; b++) begin step_edge(); settle("burst"); end
    chk("burst.done", 32'(done), 32'(one));
    req = '0; settle("burst");
  endtask

  initial begin
    logic [RW-1:0] d0;

    // Reset
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check_all("reset");
    chk("reset.grant", 32'(grant), 32'd0);
    @(posedge clk); #1;
    check_all("reset_hold");
    rst_n = 1'b1;

    // Round robin twice: order starts at 0 both times
    rr_round("rr1");
    rr_round("rr2");

    // Single requester
    step_edge(); req = 4'b0001; rdy = '1; settle("single");
    chk("single.pre", 32'(grant), 32'd0);
    step_edge(); settle("single");
    chk("single.grant", 32'(grant), 32'h1);
    chk("single.en1", 32'(prng_enable), 32'd1);
    d0 = rand_data;
    step_edge(); settle("single");
    chk("single.en2", 32'(prng_enable), 32'd1);
    chk("single.beat2", 32'(rand_data), 32'(xs(d0)));
    step_edge(); settle("single");
    chk("single.done", 32'(done), 32'h1);
    chk("single.idle", 32'(grant), 32'd0);
    req = '0; settle("single");

    // Stall: requester 1 holds ready low for 5 cycles after its first beat
    step_edge(); req = 4'b0010; rdy = '1; settle("stall");
    step_edge(); settle("stall");
    chk("stall.grant", 32'(grant), 32'h2);
    step_edge(); rdy = '0; settle("stall");
    d0 = rand_data;
    chk("stall.en", 32'(prng_enable), 32'd0);
    repeat (4) begin
      step_edge(); settle("stall");
      chk("stall.valid", 32'(rand_valid), 32'h2);
      chk("stall.data", 32'(rand_data), 32'(d0));
      chk("stall.en", 32'(prng_enable), 32'd0);
    end
    step_edge(); rdy = '1; settle("stall");
    chk("stall.resume", 32'(prng_enable), 32'd1);
    step_edge(); settle("stall");
    chk("stall.done", 32'(done), 32'h2);
    req = '0; settle("stall");

    // Withdrawal: requester 2 drops after beat 1, requester 3 pending
    step_edge(); req = 4'b1100; rdy = '1; settle("wd");
    step_edge(); settle("wd");
    chk("wd.grant", 32'(grant), 32'h4);
    step_edge(); req = 4'b1000; settle("wd");
    chk("wd.en", 32'(prng_enable), 32'd0);
    step_edge(); settle("wd");
    chk("wd.idle", 32'(grant), 32'd0);
    chk("wd.nodone", 32'(done), 32'd0);
    step_edge(); settle("wd");
    chk("wd.next", 32'(grant), 32'h8);
    for (int c = 0; c < 10; c++) begin
      step_edge(); req = req & ~m_done; settle("wd");
      if (req == '0 && grant == '0 && done == '0) break;
    end
    chk("wd.drained", 32'(grant), 32'd0);

    // Reset mid-burst
    step_edge(); req = 4'b0001; rdy = '1; settle("mrst");
    step_edge(); settle("mrst");
    chk("mrst.grant", 32'(grant), 32'h1);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("mrst.grant0", 32'(grant), 32'd0);
    chk("mrst.valid0", 32'(rand_valid), 32'd0);
    chk("mrst.done0", 32'(done), 32'd0);
    chk("mrst.en0", 32'(prng_enable), 32'd0);
    chk("mrst.stat0", stat_beats, 32'd0);
    repeat (2) begin @(posedge clk); #1; check_all("mrst_hold"); end
    rst_n = 1'b1;
    step_edge(); settle("mrst");
    chk("mrst.regrant", 32'(grant), 32'h1);
    step_edge(); settle("mrst");
    chk("mrst.beat2", 32'(done), 32'd0);
    step_edge(); settle("mrst");
    chk("mrst.done", 32'(done), 32'h1);
    req = '0; settle("mrst");

    // Ten bursts, one with a 3-cycle stall
    for (int b = 0; b < 10; b++) run_burst(b % NR, (b == 4) ? 3 : 0);
`ifdef PRNG_ARB_STATS_EN
    chk("stats.total", stat_beats, 32'(BL + 10 * BL));
`else
    chk("stats.total", stat_beats, 32'd0);
`endif

    // Randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      step_edge();
      for (int i = 0; i < NR; i++) begin
        if (m_done[i])                      req[i] = ($urandom_range(0, 3) == 0);
        else if (!req[i])                   req[i] = ($urandom_range(0, 2) == 0);
        else if ($urandom_range(0, 19) == 0) req[i] = 1'b0;
      end
      rdy = NR'($urandom);
      settle("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
